serial_offset_code_converter: RTL and testbench
===============================================

Name: serial_offset_code_converter

Overview:
- Parametrised bit-serial, LSB-first offset-code converter; generalises the 4-bit serial excess-3-to-binary converter.
- Per word of W bits: subtract OFFSET (excess-K to binary) or add OFFSET (binary to excess-K), selected per word by a mode input.
- Adds input-valid gating, word-start resync, a registered output with valid, a word-done strobe and an overflow/underflow flag.
- Sits between the serial data source and downstream serial consumers in the code-conversion datapath.

Parameters:
- W, 4, word width in bits (>=2).
- OFFSET, 3, constant added/subtracted per word (0 <= OFFSET < 2^W).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in  input  1  serial data bit, LSB first.
- in_valid  input  1  bit on in is consumed this cycle only when high.
- sof  input  1  start-of-word; when high with in_valid, the current bit is bit 0 of a new word.
- mode  input  1  0 = subtract OFFSET (excess-K to binary), 1 = add OFFSET (binary to excess-K); sampled on bit 0 only.
- out  output  1  converted serial bit, LSB first, registered.
- out_valid  output  1  out holds a valid converted bit.
- word_done  output  1  one-cycle strobe coincident with out_valid for bit W-1.
- err  output  1  valid while word_done is high: 1 = carry out (add) or borrow out (sub) from the MSB.

Behaviour:
- Reset (rst low, asynchronous): bit counter = 0; carry/borrow = 0; latched mode = 0. out, out_valid, word_done, err = 0. Reset mid-word discards the partial word; the first accepted bit after release is bit 0.
- Bit counter cnt runs 0..W-1 and advances only on accepted bits (in_valid high). It wraps W-1 -> 0.
- sof with in_valid forces the accepted bit to be bit 0 regardless of cnt. The partial word is abandoned with no word_done and no err.
- sof without in_valid is ignored.
- At bit 0: latch mode and use carry/borrow-in = 0. For bits 1..W-1, use the stored latched mode and carry/borrow. A mode change mid-word has no effect.
- Let k = OFFSET[cnt]. For each accepted bit:
  - Add: r = in^k^c; c_next = (in&k)|(in&c)|(k&c).
  - Sub: r = in^k^b; b_next = (~in&k)|(~in&b)|(k&b).
- Latency: one cycle. The cycle after an accepted bit, out = r and out_valid = 1.
- The cycle after a cycle with in_valid low: out_valid = 0 and out holds its last value.
- Back-to-back words with no idle cycle are supported at full rate (one bit per clock).
- On bit W-1: word_done = 1 and err = final carry (add) or final borrow (sub), both in the same cycle as out_valid. The result word is modulo 2^W.
- At all other times, word_done = 0 and err = 0.
- Sub with input below OFFSET (an invalid excess-K code) gives err = 1. Add with input + OFFSET >= 2^W gives err = 1.
- Implementation: small FSM or counter plus a carry register; no word buffering.

Test Plan (W=4, OFFSET=3; bits listed LSB first, one per clock, in_valid high unless stated):
- Reset: hold rst low for 7 ns mid-stream. Required: all outputs 0 immediately (asynchronous). After release, the next accepted bit is treated as bit 0.
- Sub, 1100 (12) in as 0,0,1,1. Required: out 1,0,0,1 (9) one cycle later; word_done on the 4th out_valid; err = 0. Follow immediately with 1000 (8) in as 0,0,0,1. Required: out 1,0,1,0 (5); no gap in out_valid.
- Sub underflow, 0010 (2) in as 0,1,0,0. Required: out 1,1,1,1 (15), err = 1 with word_done.
- Add, 0101 in as 1,0,1,0. Required: out 0,0,0,1 (8), err = 0. Add 1110 in as 0,1,1,1. Required: out 1,0,0,0 (1), err = 1.
- Gating: sub word 0,0,1,1 with in_valid low for 2 cycles between bits 1 and 2. Required: out_valid low in the matching cycles; out still 1,0,0,1; word_done only on the 4th valid bit.
- Resync: send 2 bits, then assert sof with a new word 1,0,1,0 in add mode (mode toggled mid-abandoned-word). Required: no word_done for the partial word; new word gives 0,0,0,1 with err = 0.

Source files
------------

// File: rtl/serial_offset_code_converter.sv
// Bit-serial, LSB-first offset-code converter: per W-bit word, adds OFFSET
// (binary -> excess-K) or subtracts it (excess-K -> binary), one bit per clock.
module serial_offset_code_converter #(
  parameter int W      = 4,
  parameter int OFFSET = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  input  logic in_valid,
  input  logic sof,
  input  logic mode,
  output logic out,
  output logic out_valid,
  output logic word_done,
  output logic err
);

  localparam int            CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [W-1:0]  K  = W'(OFFSET);

  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic          r_mode;

  logic [CW-1:0] w_idx;
  logic          w_bit0;
  logic          w_last;
  logic          w_k;
  logic          w_mode;
  logic          w_cin;
  logic          w_gen;
  logic          w_r;
  logic          w_cnext;

  // Handshake: a bit is consumed only in a cycle with in_valid high; sof with
  // in_valid restarts the word at bit 0. Outputs follow one cycle later.
  always_comb begin
    w_idx   = sof ? '0 : r_cnt;
    w_bit0  = (w_idx == '0);
    w_last  = (w_idx == CW'(W - 1));
    w_k     = K[w_idx];
    w_mode  = w_bit0 ? mode : r_mode;
    w_cin   = w_bit0 ? 1'b0 : r_carry;
    // Borrow generation is carry generation with the data bit inverted.
    w_gen   = w_mode ? in : ~in;
    w_r     = in ^ w_k ^ w_cin;
    w_cnext = (w_gen & w_k) | (w_gen & w_cin) | (w_k & w_cin);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_mode    <= 1'b0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      word_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (in_valid) begin
        r_cnt   <= w_last ? '0 : w_idx + CW'(1);
        r_carry <= w_cnext;
        r_mode  <= w_mode;
        out     <= w_r;
      end
      out_valid <= in_valid;
      word_done <= in_valid & w_last;
      err       <= in_valid & w_last & w_cnext;
    end
  end

endmodule

// File: tb/tb_serial_offset_code_converter.sv
// Directed bench for serial_offset_code_converter (W=4, OFFSET=3): an arithmetic
// word model predicts every output cycle; assembled words are pinned to literals.
module tb_serial_offset_code_converter;

  localparam int W   = 4;
  localparam int OFF = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in = 1'b0, in_valid = 1'b0, sof = 1'b0, mode = 1'b0;
  logic out, out_valid, word_done, err;

  int n_vec = 0;
  int n_err = 0;

  // Expected per output cycle: {out_valid, out, word_done, err}
  logic [3:0]   exp_q[$];
  // Completed words seen on the output: {err, word}
  logic [W:0]   got_q[$];
  logic [W-1:0] acc = '0;

  // Model state: arithmetic on the partial word received so far
  int   m_cnt = 0;
  int   m_val = 0;
  int   m_mode = 0;
  logic m_last_out = 1'b0;

  serial_offset_code_converter #(.W(W), .OFFSET(OFF)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .sof(sof), .mode(mode),
    .out(out), .out_valid(out_valid), .word_done(word_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and predict the matching output cycle.
  task automatic drive(input logic b, input logic v, input logic s, input logic m);
    int   full;
    logic r, last, e;
    @(negedge clk);
    in = b; in_valid = v; sof = s; mode = m;
    if (v) begin
      if (s) m_cnt = 0;
      if (m_cnt == 0) begin
        m_mode = int'(m);
        m_val  = 0;
      end
      m_val = m_val | (int'(b) << m_cnt);
      full  = (m_mode != 0) ? m_val + OFF : m_val - OFF;
      r     = full[m_cnt];
      last  = (m_cnt == W - 1);
      e     = last && ((m_mode != 0) ? (full >= (1 << W)) : (full < 0));
      m_cnt = last ? 0 : m_cnt + 1;
      m_last_out = r;
      exp_q.push_back({1'b1, r, last, e});
    end else begin
      exp_q.push_back({1'b0, m_last_out, 1'b0, 1'b0});
    end
  endtask

  task automatic send_word(input int x, input logic m, input logic s);
    for (int i = 0; i < W; i++) drive(x[i], 1'b1, (i == 0) ? s : 1'b0, m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_word(input string name, input int word, input int e);
    logic [W:0] g;
    if (got_q.size() == 0) begin
      chk({name, "_present"}, 0, 1);
    end else begin
      g = got_q.pop_front();
      chk({name, "_word"}, int'(g[W-1:0]), word);
      chk({name, "_err"}, int'(g[W]), e);
    end
  endtask

  // Compare process: one check per modelled output cycle.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cycle{valid,out,done,err}", int'({out_valid, out, word_done, err}), int'(e));
      end
      if (out_valid) begin
        acc = {out, acc[W-1:1]};
        if (word_done) got_q.push_back({err, acc});
      end
    end
  end

  initial begin
    // Reset from time zero
    repeat (2) @(negedge clk);
    chk("rst_out", int'(out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_word_done", int'(word_done), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b1;

    // Sub 12 then 8, back to back
    send_word(12, 1'b0, 1'b0);
    send_word(8, 1'b0, 1'b0);
    idle(2);
    expect_word("sub12", 9, 0);
    expect_word("sub8", 5, 0);

    // Sub underflow
    send_word(2, 1'b0, 1'b0);
    idle(2);
    expect_word("sub2", 15, 1);

    // Add, with and without carry out
    send_word(5, 1'b1, 1'b0);
    send_word(14, 1'b1, 1'b0);
    idle(2);
    expect_word("add5", 8, 0);
    expect_word("add14", 1, 1);

    // Gating: two idle cycles between bits 1 and 2
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    expect_word("gated_sub12", 9, 0);
    chk("gated_extra_words", got_q.size(), 0);

    // Resync: abandon a 2-bit sub word, sof starts an add word
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    send_word(5, 1'b1, 1'b1);
    idle(2);
    expect_word("resync_add5", 8, 0);
    chk("resync_extra_words", got_q.size(), 0);

    // sof without in_valid is ignored mid-word
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    idle(2);
    expect_word("sof_ignored_sub12", 9, 0);

    // Asynchronous reset mid-word (rst low for 7 ns)
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("async_rst_out", int'(out), 0);
    chk("async_rst_out_valid", int'(out_valid), 0);
    chk("async_rst_word_done", int'(word_done), 0);
    chk("async_rst_err", int'(err), 0);
    m_cnt = 0;
    m_last_out = 1'b0;
    #6 rst = 1'b1;
    send_word(12, 1'b0, 1'b0);
    idle(2);
    expect_word("post_rst_sub12", 9, 0);
    chk("post_rst_extra_words", got_q.size(), 0);

    // Sweep every code in both modes, back to back; the cycle model checks it
    for (int x = 0; x < (1 << W); x++) begin
      send_word(x, 1'b0, 1'b0);
      send_word(x, 1'b1, 1'b0);
    end
    idle(2);
    chk("sweep_words", got_q.size(), 2 * (1 << W));
    got_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
